// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: round-robin front end that shares one ALU slice
// between requesters A and B, holds the ALU inputs for ALU_LAT cycles,
// captures the result and hands it back to the owner with valid/ready.
module alu_req_sequencer #(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ReqA_Valid,
   input  logic [1:0]       ReqA_Op,
   input  logic [WIDTH-1:0] ReqA_X,
   input  logic [WIDTH-1:0] ReqA_Y,
   output logic             ReqA_Ready,
   input  logic             ReqB_Valid,
   input  logic [1:0]       ReqB_Op,
   input  logic [WIDTH-1:0] ReqB_X,
   input  logic [WIDTH-1:0] ReqB_Y,
   output logic             ReqB_Ready,
   output logic             RespA_Valid,
   input  logic             RespA_Ready,
   output logic             RespB_Valid,
   input  logic             RespB_Ready,
   output logic [WIDTH-1:0] Resp_Data,
   output logic [1:0]       Control,
   output logic [WIDTH-1:0] Operand_X,
   output logic [WIDTH-1:0] Operand_Y,
   input  logic [WIDTH-1:0] ALU_Result,
   output logic             Busy
);

   localparam int CNT_W = $clog2(ALU_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_b;
   logic             owner_b;
   logic [CNT_W-1:0] cnt;
   logic             grant_a;
   logic             grant_b;

   // Round-robin pick: a lone requester always wins, a tie goes to whoever was not served last.
   always_comb begin
      grant_a = ReqA_Valid && (!ReqB_Valid || last_b);
      grant_b = ReqB_Valid && (!ReqA_Valid || !last_b);
   end

   // Next-state and handshake decode; Ready/Valid are suppressed while Reset is high so no transfer is ever lost.
   always_comb begin
      state_next  = state;
      ReqA_Ready  = 1'b0;
      ReqB_Ready  = 1'b0;
      RespA_Valid = 1'b0;
      RespB_Valid = 1'b0;
      case (state)
         IDLE: begin
            ReqA_Ready = grant_a && !Reset;
            ReqB_Ready = grant_b && !Reset;
            if (grant_a || grant_b) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (cnt == CNT_LAST) begin
               state_next = RESP;
            end
         end
         RESP: begin
            RespA_Valid = !owner_b && !Reset;
            RespB_Valid = owner_b && !Reset;
            if ((!owner_b && RespA_Ready) || (owner_b && RespB_Ready)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register; synchronous reset abandons any operation in flight.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request latch, owner/round-robin bookkeeping, settle counter and result capture.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         last_b    <= 1'b1;
         owner_b   <= 1'b0;
         cnt       <= '0;
         Control   <= 2'b00;
         Operand_X <= '0;
         Operand_Y <= '0;
         Resp_Data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_a) begin
                  Control   <= ReqA_Op;
                  Operand_X <= ReqA_X;
                  Operand_Y <= ReqA_Y;
                  owner_b   <= 1'b0;
                  last_b    <= 1'b0;
                  cnt       <= '0;
               end else if (grant_b) begin
                  Control   <= ReqB_Op;
                  Operand_X <= ReqB_X;
                  Operand_Y <= ReqB_Y;
                  owner_b   <= 1'b1;
                  last_b    <= 1'b1;
                  cnt       <= '0;
               end
            end
            EXEC: begin
               if (cnt == CNT_LAST) begin
                  Resp_Data <= ALU_Result;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Busy mirrors "not idle" so upstream logic can see the ALU is claimed.
   always_comb begin
      Busy = (state != IDLE);
   end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: drives two sequencer instances (ALU_LAT=1 and 3, only
// one active at a time) against a transaction-level model of arbitration,
// latency and result return, with directed scenarios followed by random traffic.
module tb_alu_req_sequencer;

   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic lat_sel = 1'b0;

   logic             req_a_valid = 1'b0;
   logic [1:0]       req_a_op = 2'b00;
   logic [WIDTH-1:0] req_a_x = '0;
   logic [WIDTH-1:0] req_a_y = '0;
   logic             req_b_valid = 1'b0;
   logic [1:0]       req_b_op = 2'b00;
   logic [WIDTH-1:0] req_b_x = '0;
   logic [WIDTH-1:0] req_b_y = '0;
   logic             resp_a_ready = 1'b0;
   logic             resp_b_ready = 1'b0;

   logic [1:0]       dut_reset;
   logic [1:0]       o_req_a_ready;
   logic [1:0]       o_req_b_ready;
   logic [1:0]       o_resp_a_valid;
   logic [1:0]       o_resp_b_valid;
   logic [1:0]       o_busy;
   logic [WIDTH-1:0] o_resp_data [2];
   logic [WIDTH-1:0] o_operand_x [2];
   logic [WIDTH-1:0] o_operand_y [2];
   logic [WIDTH-1:0] o_alu_result [2];
   logic [1:0]       o_control [2];

   logic             cur_req_a_ready;
   logic             cur_req_b_ready;
   logic             cur_resp_a_valid;
   logic             cur_resp_b_valid;
   logic             cur_busy;
   logic [WIDTH-1:0] cur_resp_data;
   logic [WIDTH-1:0] cur_operand_x;
   logic [WIDTH-1:0] cur_operand_y;
   logic [1:0]       cur_control;

   // Reference model state: at most one outstanding transaction plus arbitration history.
   int               checks = 0;
   int               passes = 0;
   int               cyc = 0;
   int               cur_lat = 1;
   bit               m_out = 1'b0;
   bit               m_owner_b = 1'b0;
   bit               m_last_b = 1'b1;
   int               m_start = 0;
   logic [WIDTH-1:0] m_data = '0;
   logic [1:0]       m_ctrl = 2'b00;
   logic [WIDTH-1:0] m_x = '0;
   logic [WIDTH-1:0] m_y = '0;

   // Random requester state: a pending request is held until accepted.
   bit               pa = 1'b0;
   bit               pb = 1'b0;
   logic [1:0]       pa_op = 2'b00;
   logic [1:0]       pb_op = 2'b00;
   logic [WIDTH-1:0] pa_x = '0;
   logic [WIDTH-1:0] pa_y = '0;
   logic [WIDTH-1:0] pb_x = '0;
   logic [WIDTH-1:0] pb_y = '0;

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] aluRef(input logic [1:0] op, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      case (op)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x + y;
         default: return x - y;
      endcase
   endfunction

   // Only the selected instance runs; the other is parked in reset.
   assign dut_reset[0] = reset | lat_sel;
   assign dut_reset[1] = reset | ~lat_sel;

   // Behavioural ALU slice behind each instance.
   assign o_alu_result[0] = aluRef(o_control[0], o_operand_x[0], o_operand_y[0]);
   assign o_alu_result[1] = aluRef(o_control[1], o_operand_x[1], o_operand_y[1]);

   alu_req_sequencer #(.WIDTH(WIDTH), .ALU_LAT(1)) u_dut_lat1 (
      .Clk(clk), .Reset(dut_reset[0]),
      .ReqA_Valid(req_a_valid), .ReqA_Op(req_a_op), .ReqA_X(req_a_x), .ReqA_Y(req_a_y),
      .ReqA_Ready(o_req_a_ready[0]),
      .ReqB_Valid(req_b_valid), .ReqB_Op(req_b_op), .ReqB_X(req_b_x), .ReqB_Y(req_b_y),
      .ReqB_Ready(o_req_b_ready[0]),
      .RespA_Valid(o_resp_a_valid[0]), .RespA_Ready(resp_a_ready),
      .RespB_Valid(o_resp_b_valid[0]), .RespB_Ready(resp_b_ready),
      .Resp_Data(o_resp_data[0]), .Control(o_control[0]),
      .Operand_X(o_operand_x[0]), .Operand_Y(o_operand_y[0]),
      .ALU_Result(o_alu_result[0]), .Busy(o_busy[0])
   );

   alu_req_sequencer #(.WIDTH(WIDTH), .ALU_LAT(3)) u_dut_lat3 (
      .Clk(clk), .Reset(dut_reset[1]),
      .ReqA_Valid(req_a_valid), .ReqA_Op(req_a_op), .ReqA_X(req_a_x), .ReqA_Y(req_a_y),
      .ReqA_Ready(o_req_a_ready[1]),
      .ReqB_Valid(req_b_valid), .ReqB_Op(req_b_op), .ReqB_X(req_b_x), .ReqB_Y(req_b_y),
      .ReqB_Ready(o_req_b_ready[1]),
      .RespA_Valid(o_resp_a_valid[1]), .RespA_Ready(resp_a_ready),
      .RespB_Valid(o_resp_b_valid[1]), .RespB_Ready(resp_b_ready),
      .Resp_Data(o_resp_data[1]), .Control(o_control[1]),
      .Operand_X(o_operand_x[1]), .Operand_Y(o_operand_y[1]),
      .ALU_Result(o_alu_result[1]), .Busy(o_busy[1])
   );

   // Present the active instance's outputs under one set of names.
   always_comb begin
      cur_req_a_ready  = o_req_a_ready[lat_sel];
      cur_req_b_ready  = o_req_b_ready[lat_sel];
      cur_resp_a_valid = o_resp_a_valid[lat_sel];
      cur_resp_b_valid = o_resp_b_valid[lat_sel];
      cur_busy         = o_busy[lat_sel];
      cur_resp_data    = o_resp_data[lat_sel];
      cur_operand_x    = o_operand_x[lat_sel];
      cur_operand_y    = o_operand_y[lat_sel];
      cur_control      = o_control[lat_sel];
   end

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, lat %0d)",
                  tag, actual, expected, cyc, cur_lat);
      end
   endtask

   // Switch the active instance; it comes up from reset so the model restarts too.
   task automatic selectDut(input logic sel);
      reset     = 1'b1;
      lat_sel   = sel;
      cur_lat   = sel ? 3 : 1;
      m_out     = 1'b0;
      m_last_b  = 1'b1;
      m_ctrl    = 2'b00;
      m_x       = '0;
      m_y       = '0;
      m_data    = '0;
      pa        = 1'b0;
      pb        = 1'b0;
   endtask

   // One clock cycle: drive inputs, check every output against the model, advance the model.
   task automatic applyStimulus(input bit rst,
                                input bit va, input logic [1:0] opa,
                                input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
                                input bit vb, input logic [1:0] opb,
                                input logic [WIDTH-1:0] xb, input logic [WIDTH-1:0] yb,
                                input bit ra, input bit rb,
                                output bit acc_a, output bit acc_b);
      bit exp_ra;
      bit exp_rb;
      bit exp_va;
      bit exp_vb;
      bit settled;
      @(negedge clk);
      reset        = rst;
      req_a_valid  = va;
      req_a_op     = opa;
      req_a_x      = xa;
      req_a_y      = ya;
      req_b_valid  = vb;
      req_b_op     = opb;
      req_b_x      = xb;
      req_b_y      = yb;
      resp_a_ready = ra;
      resp_b_ready = rb;
      #1;
      settled = m_out && (cyc >= m_start + cur_lat + 1);
      exp_ra  = !rst && !m_out && va && (!vb || m_last_b);
      exp_rb  = !rst && !m_out && vb && (!va || !m_last_b);
      exp_va  = !rst && settled && !m_owner_b;
      exp_vb  = !rst && settled && m_owner_b;
      checkOutput("req_a_ready", 16'(cur_req_a_ready), 16'(exp_ra));
      checkOutput("req_b_ready", 16'(cur_req_b_ready), 16'(exp_rb));
      checkOutput("resp_a_valid", 16'(cur_resp_a_valid), 16'(exp_va));
      checkOutput("resp_b_valid", 16'(cur_resp_b_valid), 16'(exp_vb));
      if (!rst) begin
         checkOutput("busy", 16'(cur_busy), 16'(m_out));
      end
      checkOutput("control", 16'(cur_control), 16'(m_ctrl));
      checkOutput("operand_x", cur_operand_x, m_x);
      checkOutput("operand_y", cur_operand_y, m_y);
      if (exp_va || exp_vb) begin
         checkOutput("resp_data", cur_resp_data, m_data);
      end
      acc_a = exp_ra;
      acc_b = exp_rb;
      if (rst) begin
         m_out    = 1'b0;
         m_last_b = 1'b1;
         m_ctrl   = 2'b00;
         m_x      = '0;
         m_y      = '0;
         m_data   = '0;
      end else if (exp_ra || exp_rb) begin
         m_out     = 1'b1;
         m_owner_b = exp_rb;
         m_last_b  = exp_rb;
         m_start   = cyc;
         m_ctrl    = exp_rb ? opb : opa;
         m_x       = exp_rb ? xb : xa;
         m_y       = exp_rb ? yb : ya;
         m_data    = aluRef(m_ctrl, m_x, m_y);
      end else if ((exp_va && ra) || (exp_vb && rb)) begin
         m_out = 1'b0;
      end
      cyc++;
   endtask

   task automatic stepIdle(input bit rst, input bit ra, input bit rb);
      bit acc_a;
      bit acc_b;
      applyStimulus(rst, 1'b0, 2'b00, '0, '0, 1'b0, 2'b00, '0, '0, ra, rb, acc_a, acc_b);
   endtask

   // Random traffic: requesters hold requests until accepted, consumers stall randomly, rare resets.
   task automatic runRandom(input int n);
      bit acc_a;
      bit acc_b;
      bit rst;
      bit ra;
      bit rb;
      for (int i = 0; i < n; i++) begin
         if (!pa && ($urandom_range(0, 2) != 0)) begin
            pa    = 1'b1;
            pa_op = 2'($urandom_range(0, 3));
            pa_x  = 16'($urandom);
            pa_y  = 16'($urandom);
         end
         if (!pb && ($urandom_range(0, 2) != 0)) begin
            pb    = 1'b1;
            pb_op = 2'($urandom_range(0, 3));
            pb_x  = 16'($urandom);
            pb_y  = 16'($urandom);
         end
         rst = ($urandom_range(0, 63) == 0);
         ra  = ($urandom_range(0, 3) != 0);
         rb  = ($urandom_range(0, 3) != 0);
         applyStimulus(rst, pa, pa_op, pa_x, pa_y, pb, pb_op, pb_x, pb_y, ra, rb, acc_a, acc_b);
         if (acc_a) pa = 1'b0;
         if (acc_b) pb = 1'b0;
      end
   endtask

   // Directed scenarios at both latencies, then randomized traffic.
   initial begin
      bit acc_a;
      bit acc_b;
      bit grants [$];

      // Reset values, ALU_LAT=1.
      selectDut(1'b0);
      stepIdle(1'b1, 1'b0, 1'b0);
      stepIdle(1'b1, 1'b0, 1'b0);
      stepIdle(1'b0, 1'b0, 1'b0);
      checkOutput("rst_resp_data", cur_resp_data, 16'h0000);
      checkOutput("rst_busy", 16'(cur_busy), 16'h0000);

      // A: ADD 0x1234 + 0x0001, response two cycles after the handshake.
      applyStimulus(1'b0, 1'b1, 2'b10, 16'h1234, 16'h0001, 1'b0, 2'b00, '0, '0, 1'b1, 1'b1,
                    acc_a, acc_b);
      checkOutput("t1_ready_a", 16'(cur_req_a_ready), 16'h0001);
      for (int k = 1; k <= 3; k++) begin
         stepIdle(1'b0, 1'b1, 1'b1);
         if (k == 1) checkOutput("t1_control", 16'(cur_control), 16'h0002);
         if (k == 2) begin
            checkOutput("t1_valid", 16'(cur_resp_a_valid), 16'h0001);
            checkOutput("t1_data", cur_resp_data, 16'h1235);
         end
      end

      // B: SUB 0x0005 - 0x0007.
      applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 2'b11, 16'h0005, 16'h0007, 1'b1, 1'b1,
                    acc_a, acc_b);
      for (int k = 1; k <= 3; k++) begin
         stepIdle(1'b0, 1'b1, 1'b1);
         if (k == 1) checkOutput("t2_add_sub_sel", 16'(&cur_control), 16'h0001);
         if (k == 2) begin
            checkOutput("t2_data", cur_resp_data, 16'hFFFE);
            checkOutput("t2_valid_a", 16'(cur_resp_a_valid), 16'h0000);
            checkOutput("t2_valid_b", 16'(cur_resp_b_valid), 16'h0001);
         end
      end

      // Continuous contention right after reset: A, B, A, B.
      stepIdle(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, 1'b1, 2'b00, 16'h0F0F, 16'h00FF, 1'b1, 2'b00, 16'hF0F0, 16'h0FF0,
                       1'b1, 1'b1, acc_a, acc_b);
         if (cur_req_a_ready) grants.push_back(1'b0);
         if (cur_req_b_ready) grants.push_back(1'b1);
      end
      checkOutput("t3_grant_count", 16'(grants.size()), 16'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++) begin
         checkOutput("t3_grant_order", 16'(grants[i]), 16'(i % 2));
      end
      for (int k = 0; k < 3; k++) stepIdle(1'b0, 1'b1, 1'b1);

      // A's response stalled for 5 cycles while B waits.
      applyStimulus(1'b0, 1'b1, 2'b10, 16'd10, 16'd20, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0,
                    acc_a, acc_b);
      pb = 1'b1;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, pb, 2'b01, 16'h00F0, 16'h000F,
                       (k >= 6), 1'b1, acc_a, acc_b);
         if (acc_b) pb = 1'b0;
         if (k >= 1 && k <= 5) begin
            checkOutput("t4_hold_valid", 16'(cur_resp_a_valid), 16'h0001);
            checkOutput("t4_hold_data", cur_resp_data, 16'd30);
            checkOutput("t4_b_blocked", 16'(cur_req_b_ready), 16'h0000);
         end
      end

      runRandom(400);

      // ALU_LAT=3: OR with three EXEC cycles.
      selectDut(1'b1);
      stepIdle(1'b1, 1'b0, 1'b0);
      stepIdle(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'b01, 16'hF0F0, 16'h0F0F, 1'b0, 2'b00, '0, '0, 1'b1, 1'b1,
                    acc_a, acc_b);
      for (int k = 1; k <= 5; k++) begin
         stepIdle(1'b0, 1'b1, 1'b1);
         if (k <= 3) checkOutput("t6_busy", 16'(cur_busy), 16'h0001);
         if (k == 3) checkOutput("t6_not_yet", 16'(cur_resp_a_valid), 16'h0000);
         if (k == 4) begin
            checkOutput("t6_valid", 16'(cur_resp_a_valid), 16'h0001);
            checkOutput("t6_data", cur_resp_data, 16'hFFFF);
         end
      end

      // Reset in the middle of EXEC, then a clean request.
      applyStimulus(1'b0, 1'b1, 2'b11, 16'h0100, 16'h0001, 1'b0, 2'b00, '0, '0, 1'b1, 1'b1,
                    acc_a, acc_b);
      stepIdle(1'b0, 1'b1, 1'b1);
      stepIdle(1'b1, 1'b1, 1'b1);
      stepIdle(1'b0, 1'b1, 1'b1);
      checkOutput("t5_busy", 16'(cur_busy), 16'h0000);
      checkOutput("t5_control", 16'(cur_control), 16'h0000);
      checkOutput("t5_no_valid", 16'(cur_resp_a_valid | cur_resp_b_valid), 16'h0000);
      applyStimulus(1'b0, 1'b1, 2'b10, 16'd3, 16'd4, 1'b0, 2'b00, '0, '0, 1'b1, 1'b1,
                    acc_a, acc_b);
      for (int k = 1; k <= 5; k++) begin
         stepIdle(1'b0, 1'b1, 1'b1);
         if (k == 4) checkOutput("t5_after_data", cur_resp_data, 16'd7);
      end

      runRandom(400);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
